// File: rtl/gselect_predictor_param.sv
// Gselect branch predictor: {low PC bits, speculative GHR} indexes a table of
// saturating counters; fetch predicts, the resolution unit trains and repairs history.
module gselect_predictor_param #(
  parameter int PC_W     = 8,
  parameter int PC_BITS  = 2,
  parameter int GHR_BITS = 2,
  parameter int CTR_W    = 2,
  parameter int CTR_INIT = 1,
  parameter int CNT_W    = 16,
  localparam int IDX_W   = PC_BITS + GHR_BITS
) (
  input  logic                clk,
  input  logic                reset,
  output logic                ready,
  input  logic                pred_valid,
  input  logic [PC_W-1:0]     pred_pc,
  output logic                pred_resp_valid,
  output logic                pred_taken,
  output logic [IDX_W-1:0]    pred_index,
  output logic [GHR_BITS-1:0] pred_ghr,
  input  logic                upd_valid,
  input  logic [IDX_W-1:0]    upd_index,
  input  logic [GHR_BITS-1:0] upd_ghr,
  input  logic                upd_taken,
  input  logic                upd_mispredict,
  output logic [GHR_BITS-1:0] ghr,
  output logic [CNT_W-1:0]    upd_count,
  output logic [CNT_W-1:0]    mispredict_count
);

  localparam int DEPTH = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX   = IDX_W'(DEPTH - 1);
  localparam logic [CTR_W-1:0] CTR_MAX    = '1;
  localparam logic [CTR_W-1:0] CTR_INIT_V = CTR_W'(CTR_INIT);
  localparam logic [CNT_W-1:0] CNT_MAX    = '1;

  localparam logic STATE_INIT = 1'b0;
  localparam logic STATE_RUN  = 1'b1;

  logic                state;
  logic [IDX_W-1:0]    init_ptr;
  logic [CTR_W-1:0]    ctr_table [DEPTH];

  logic                pred_fire;
  logic                upd_fire;
  logic [IDX_W-1:0]    pred_idx;
  logic [CTR_W-1:0]    pred_ctr;
  logic                pred_dir;
  logic [CTR_W-1:0]    upd_old;
  logic [CTR_W-1:0]    upd_new;
  logic [GHR_BITS:0]   spec_ext;
  logic [GHR_BITS:0]   repair_ext;

  // Only the low PC bits take part in indexing; the rest are deliberately dropped.
  logic unused_pc_bits;
  assign unused_pc_bits = ^pred_pc;

  assign ready     = (state == STATE_RUN);
  assign pred_fire = pred_valid && ready;
  assign upd_fire  = upd_valid && ready;

  assign pred_idx = {pred_pc[PC_BITS-1:0], ghr};
  assign pred_ctr = ctr_table[pred_idx];
  assign pred_dir = pred_ctr[CTR_W-1];
  assign upd_old  = ctr_table[upd_index];

  // Shifting through a one-bit-wider vector keeps GHR_BITS=1 legal without special cases.
  assign spec_ext   = {ghr, pred_dir};
  assign repair_ext = {upd_ghr, upd_taken};

  always_comb begin
    upd_new = upd_old;
    if (upd_taken && (upd_old != CTR_MAX)) begin
      upd_new = upd_old + 1'b1;
    end else if (!upd_taken && (upd_old != '0)) begin
      upd_new = upd_old - 1'b1;
    end
  end

  // Table has no reset; the INIT walk fills it, and the predict read sees pre-write data.
  always_ff @(posedge clk) begin
    if (state == STATE_INIT) begin
      ctr_table[init_ptr] <= CTR_INIT_V;
    end else if (upd_fire) begin
      ctr_table[upd_index] <= upd_new;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state            <= STATE_INIT;
      init_ptr         <= '0;
      ghr              <= '0;
      pred_resp_valid  <= 1'b0;
      pred_taken       <= 1'b0;
      pred_index       <= '0;
      pred_ghr         <= '0;
      upd_count        <= '0;
      mispredict_count <= '0;
    end else begin
      pred_resp_valid <= pred_fire;

      if (state == STATE_INIT) begin
        init_ptr <= init_ptr + 1'b1;
        if (init_ptr == LAST_IDX) begin
          state <= STATE_RUN;
        end
      end

      if (pred_fire) begin
        pred_taken <= pred_dir;
        pred_index <= pred_idx;
        pred_ghr   <= ghr;
      end

      // A resolved mispredict overrides any speculative shift from this cycle.
      if (upd_fire && upd_mispredict) begin
        ghr <= repair_ext[GHR_BITS-1:0];
      end else if (pred_fire) begin
        ghr <= spec_ext[GHR_BITS-1:0];
      end

      if (upd_fire) begin
        if (upd_count != CNT_MAX) begin
          upd_count <= upd_count + 1'b1;
        end
        if (upd_mispredict && (mispredict_count != CNT_MAX)) begin
          mispredict_count <= mispredict_count + 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_gselect_predictor_param.sv
// Directed bench for gselect_predictor_param: expected prediction responses are
// queued at issue time and a negedge monitor checks each DUT response against them.
module tb_gselect_predictor_param;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       pred_valid = 1'b0;
  logic [7:0] pred_pc = '0;
  logic       upd_valid = 1'b0;
  logic [3:0] upd_index = '0;
  logic [1:0] upd_ghr = '0;
  logic       upd_taken = 1'b0;
  logic       upd_mispredict = 1'b0;

  logic        ready, pred_resp_valid, pred_taken;
  logic [3:0]  pred_index;
  logic [1:0]  pred_ghr, ghr;
  logic [15:0] upd_count, mispredict_count;

  logic        ready_s, pred_resp_valid_s, pred_taken_s;
  logic [3:0]  pred_index_s;
  logic [1:0]  pred_ghr_s, ghr_s;
  logic [1:0]  upd_count_s, mispredict_count_s;

  int n_compared = 0;
  int n_mismatched = 0;

  typedef struct {
    logic       taken;
    logic [3:0] idx;
    logic [1:0] g;
  } pred_exp_t;

  pred_exp_t exp_q[$];

  always #5 clk = ~clk;

  gselect_predictor_param dut (
    .clk(clk), .reset(reset), .ready(ready),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_resp_valid(pred_resp_valid), .pred_taken(pred_taken),
    .pred_index(pred_index), .pred_ghr(pred_ghr),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .ghr(ghr), .upd_count(upd_count), .mispredict_count(mispredict_count)
  );

  // Narrow perf counters, same stimulus, to exercise counter saturation.
  gselect_predictor_param #(.CNT_W(2)) dut_small (
    .clk(clk), .reset(reset), .ready(ready_s),
    .pred_valid(pred_valid), .pred_pc(pred_pc),
    .pred_resp_valid(pred_resp_valid_s), .pred_taken(pred_taken_s),
    .pred_index(pred_index_s), .pred_ghr(pred_ghr_s),
    .upd_valid(upd_valid), .upd_index(upd_index), .upd_ghr(upd_ghr),
    .upd_taken(upd_taken), .upd_mispredict(upd_mispredict),
    .ghr(ghr_s), .upd_count(upd_count_s), .mispredict_count(mispredict_count_s)
  );

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_compared++;
    if (actual !== expected) begin
      n_mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, actual, expected);
    end
  endtask

  // Drives one cycle of stimulus starting just after a rising edge, then idles the inputs.
  task automatic applyStimulus(input logic pv, input logic [7:0] pc,
                               input logic uv, input logic [3:0] uidx, input logic [1:0] ughr,
                               input logic ut, input logic um,
                               input logic e_taken, input logic [3:0] e_idx, input logic [1:0] e_ghr);
    pred_exp_t e;
    pred_valid = pv; pred_pc = pc;
    upd_valid = uv; upd_index = uidx; upd_ghr = ughr; upd_taken = ut; upd_mispredict = um;
    if (pv) begin
      e.taken = e_taken; e.idx = e_idx; e.g = e_ghr;
      exp_q.push_back(e);
    end
    @(posedge clk);
    #1;
    pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; upd_taken = 1'b0;
  endtask

  task automatic predict(input logic [7:0] pc, input logic e_taken, input logic [3:0] e_idx, input logic [1:0] e_ghr);
    applyStimulus(1'b1, pc, 1'b0, 4'h0, 2'b00, 1'b0, 1'b0, e_taken, e_idx, e_ghr);
  endtask

  task automatic update(input logic [3:0] uidx, input logic [1:0] ughr, input logic ut, input logic um);
    applyStimulus(1'b0, 8'h00, 1'b1, uidx, ughr, ut, um, 1'b0, 4'h0, 2'b00);
  endtask

  task automatic initWalk(input string tag);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk);
      #1;
      checkOutput($sformatf("%s_ready_c%0d", tag, i + 1), 32'(ready), 32'(i == 15));
    end
  endtask

  always @(negedge clk) begin
    if (pred_resp_valid) begin
      if (exp_q.size() == 0) begin
        checkOutput("unexpected_resp", 32'(pred_resp_valid), 32'd0);
      end else begin
        pred_exp_t e;
        e = exp_q.pop_front();
        checkOutput("resp_taken", 32'(pred_taken), 32'(e.taken));
        checkOutput("resp_index", 32'(pred_index), 32'(e.idx));
        checkOutput("resp_ghr",   32'(pred_ghr),   32'(e.g));
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    repeat (3) @(posedge clk);
    #1;
    checkOutput("reset_ready", 32'(ready), 32'd0);
    reset = 1'b0;

    // Requests held high through the init walk must be ignored.
    pred_valid = 1'b1; pred_pc = 8'h00;
    upd_valid = 1'b1; upd_index = 4'h5; upd_ghr = 2'b11; upd_taken = 1'b1; upd_mispredict = 1'b1;
    initWalk("init");
    pred_valid = 1'b0; upd_valid = 1'b0; upd_mispredict = 1'b0; upd_taken = 1'b0;
    checkOutput("init_ghr", 32'(ghr), 32'd0);
    checkOutput("init_upd_count", 32'(upd_count), 32'd0);
    checkOutput("init_misp_count", 32'(mispredict_count), 32'd0);
    checkOutput("init_resp_valid", 32'(pred_resp_valid), 32'd0);

    // Every PC predicts not-taken with CTR_INIT=1.
    predict(8'h00, 1'b0, 4'b0000, 2'b00);
    predict(8'h01, 1'b0, 4'b0100, 2'b00);
    predict(8'h02, 1'b0, 4'b1000, 2'b00);
    predict(8'hFF, 1'b0, 4'b1100, 2'b00);
    checkOutput("initpred_ghr", 32'(ghr), 32'd0);

    // Saturate idx 1001 upward; the 4th update also repairs ghr to 01.
    update(4'b1001, 2'b00, 1'b1, 1'b0);
    update(4'b1001, 2'b00, 1'b1, 1'b0);
    update(4'b1001, 2'b00, 1'b1, 1'b0);
    update(4'b1001, 2'b00, 1'b1, 1'b1);
    checkOutput("sat_ghr_repair", 32'(ghr), 32'b01);
    predict(8'h02, 1'b1, 4'b1001, 2'b01);
    checkOutput("sat_ghr_shift", 32'(ghr), 32'b11);
    repeat (5) update(4'b1001, 2'b00, 1'b0, 1'b0);
    update(4'b0000, 2'b00, 1'b1, 1'b1);
    checkOutput("sat_ghr_repair2", 32'(ghr), 32'b01);
    predict(8'h02, 1'b0, 4'b1001, 2'b01);
    checkOutput("sat_upd_count", 32'(upd_count), 32'd10);
    checkOutput("sat_misp_count", 32'(mispredict_count), 32'd2);

    // Speculative history: idx0 -> 3, ghr repaired to 00, back-to-back predicts.
    update(4'b0000, 2'b00, 1'b1, 1'b0);
    update(4'b0110, 2'b10, 1'b0, 1'b1);
    checkOutput("spec_ghr_start", 32'(ghr), 32'b00);
    predict(8'h00, 1'b1, 4'b0000, 2'b00);
    predict(8'h00, 1'b0, 4'b0001, 2'b01);
    checkOutput("spec_ghr_end", 32'(ghr), 32'b10);

    // Mispredict repair in the same cycle as a taken predict.
    update(4'b0111, 2'b01, 1'b1, 1'b1);
    checkOutput("rep_ghr_setup", 32'(ghr), 32'b11);
    applyStimulus(1'b1, 8'h01, 1'b1, 4'b1100, 2'b10, 1'b0, 1'b1, 1'b1, 4'b0111, 2'b11);
    checkOutput("rep_resp_valid", 32'(pred_resp_valid), 32'd1);
    checkOutput("rep_ghr", 32'(ghr), 32'b00);
    checkOutput("rep_misp_count", 32'(mispredict_count), 32'd5);

    // Same-index collision: predict reads the pre-update counter.
    applyStimulus(1'b1, 8'h02, 1'b1, 4'b1000, 2'b00, 1'b1, 1'b0, 1'b0, 4'b1000, 2'b00);
    predict(8'h02, 1'b1, 4'b1000, 2'b00);
    checkOutput("coll_ghr", 32'(ghr), 32'b01);
    checkOutput("coll_upd_count", 32'(upd_count), 32'd15);
    checkOutput("coll_misp_count", 32'(mispredict_count), 32'd5);
    checkOutput("small_upd_count_sat", 32'(upd_count_s), 32'd3);
    checkOutput("small_misp_count_sat", 32'(mispredict_count_s), 32'd3);

    // Asynchronous reset between edges while a response is being presented.
    predict(8'h00, 1'b0, 4'b0001, 2'b01);
    checkOutput("mid_resp_valid", 32'(pred_resp_valid), 32'd1);
    checkOutput("mid_ghr", 32'(ghr), 32'b10);
    @(negedge clk);
    #2;
    reset = 1'b1;
    #1;
    checkOutput("arst_resp_valid", 32'(pred_resp_valid), 32'd0);
    checkOutput("arst_pred_index", 32'(pred_index), 32'd0);
    checkOutput("arst_pred_ghr", 32'(pred_ghr), 32'd0);
    checkOutput("arst_ghr", 32'(ghr), 32'd0);
    checkOutput("arst_upd_count", 32'(upd_count), 32'd0);
    checkOutput("arst_misp_count", 32'(mispredict_count), 32'd0);
    checkOutput("arst_ready", 32'(ready), 32'd0);
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    initWalk("reinit");
    predict(8'h02, 1'b0, 4'b1000, 2'b00);

    repeat (2) @(posedge clk);
    #1;
    checkOutput("queue_drained", 32'(exp_q.size()), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
    $finish;
  end

endmodule

// File: doc/gselect_predictor_param.md
Name: gselect_predictor_param

Overview:
Parametrised gselect branch predictor with separate predict and update ports. The table index is formed from low PC bits concatenated with a speculative global history register (GHR). The block has a post-reset table-initialisation walk, history repair on mispredict, N-bit saturating counters, and saturating performance counters. It sits in the fetch stage: fetch queries it, and the branch resolution unit updates it.

Parameters:
PC_W, 8, branch PC width
PC_BITS, 2, low PC bits used in index (1..PC_W)
GHR_BITS, 2, history length (>=1); IDX_W = PC_BITS+GHR_BITS, table depth 2^IDX_W
CTR_W, 2, saturating counter width (>=1)
CTR_INIT, 1, counter value written during init (default weakly not-taken)
CNT_W, 16, performance counter width

Ports:
clk  in  1  clock, all state on rising edge
reset  in  1  asynchronous, active-high
ready  out  1  high when in RUN state; requests accepted only when high
pred_valid  in  1  prediction request
pred_pc  in  PC_W  PC of branch being predicted
pred_resp_valid  out  1  registered, one cycle after accepted request
pred_taken  out  1  registered prediction (counter MSB)
pred_index  out  IDX_W  registered table index used; returned by resolution unit
pred_ghr  out  GHR_BITS  registered GHR snapshot used for the index (pre-shift)
upd_valid  in  1  resolution update
upd_index  in  IDX_W  index from the matching prediction
upd_ghr  in  GHR_BITS  GHR snapshot from the matching prediction
upd_taken  in  1  actual outcome
upd_mispredict  in  1  prediction was wrong; triggers GHR repair
ghr  out  GHR_BITS  current speculative GHR
upd_count  out  CNT_W  updates accepted, saturating
mispredict_count  out  CNT_W  mispredicts accepted, saturating

Behaviour:
- Reset (async assert, any time, including mid-init or mid-run):
  - state=INIT, init pointer=0, ghr=0.
  - pred_resp_valid=0, pred_taken=0, pred_index=0, pred_ghr=0.
  - upd_count=0, mispredict_count=0, ready=0.
  - Table contents are not reset asynchronously.
- INIT state: after reset deasserts, one entry per cycle is written with CTR_INIT, pointer 0..2^IDX_W-1.
  - After the last write, state=RUN the next edge, so ready rises exactly 2^IDX_W cycles after the first post-reset edge.
  - pred_valid and upd_valid are ignored in INIT: no table, GHR or counter change, and pred_resp_valid stays 0.
- RUN state, index = {pred_pc[PC_BITS-1:0], ghr} (PC bits in the MSBs).
- Predict (pred_valid && ready):
  - Table read is combinational. taken = counter[CTR_W-1].
  - Next edge: pred_resp_valid=1, pred_taken=taken, pred_index=index, pred_ghr=ghr (the pre-shift value).
  - Next edge: ghr <= {ghr[GHR_BITS-2:0], taken}; for GHR_BITS=1, ghr <= taken.
  - pred_resp_valid=0 on cycles with no accepted request; the other pred_* outputs hold their values.
- Update (upd_valid && ready): table[upd_index] is incremented if upd_taken, else decremented.
  - The counter saturates at 2^CTR_W-1 and at 0; a saturated counter is written back unchanged.
  - upd_count increments, holding at all-ones.
  - If upd_mispredict: mispredict_count increments (saturating), and ghr <= {upd_ghr[GHR_BITS-2:0], upd_taken}.
- Simultaneous predict and update:
  - Both are accepted.
  - The prediction reads the pre-update counter (read-before-write), even at the same index.
  - Mispredict repair has priority over the speculative shift, and the predict's shift is discarded. The prediction response is still issued, using the pre-repair ghr.
- No pipeline stall. Throughput is one predict plus one update per cycle.

Test Plan:
- Init walk: reset 3 cycles, release. Defaults → ready=0 for exactly 16 cycles, then 1. Predicting every pc → pred_taken=0 (CTR_INIT=1). A pred_valid held during init → no response, ghr stays 0.
- Saturation: 4 updates with upd_taken=1 at index 4'b1001 → counter 1→2→3→3. Predict pc=2, ghr=01 → pred_taken=1. Then 5 not-taken updates → counter 0, pred_taken=0. upd_count=9.
- Speculative history: after init, set counter at idx 0 to 3, then predict pc=0 on consecutive cycles → ghr 00→01, pred_index 0 then 1, pred_ghr 00 then 01.
- Mispredict repair concurrent with predict: ghr=11, same cycle as a predict, upd_mispredict=1, upd_ghr=10, upd_taken=0 → ghr=00 (predict shift dropped), pred_resp_valid=1, mispredict_count=1.
- Same-index collision: counter=1, predict and taken-update at the same index in one cycle → pred_taken=0, then a following predict at that index → pred_taken=1.
- Reset mid-run: assert reset asynchronously between edges with pred_resp_valid=1 and ghr=10 → outputs, ghr and counters go to 0 immediately; 16-cycle init repeats. Perf counters saturating: CNT_W=2, 5 updates → upd_count=3.
